// File: rtl/uart_pwm_ctrl_pkg.sv
// Shared types and constants for the UART-to-PWM frame sequencer.
package uart_pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_PEND,
    ST_COMMIT
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

endpackage

// File: rtl/uart_pwm_frame_ctrl_gap_timer.sv
// Saturating inter-word gap counter; expired flags the cycle
// that completes TIMEOUT_CYCLES idle cycles.
module frame_gap_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !clr && (cnt_q >= LAST);

endmodule

// File: rtl/uart_pwm_frame_ctrl.sv
// Frame sequencer: sync, CHANNELS duties, XOR checksum, atomic commit.
// Optional UART_PWM_FRAME_CLAMP_EN adds DUTY_MAX clamping of staged duties.
module uart_pwm_frame_ctrl
  import uart_pwm_ctrl_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               CHANNELS       = 9,
  parameter logic [WIDTH-1:0] SYNC_WORD      = WIDTH'(SYNC_WORD_DEF),
  parameter int               TIMEOUT_CYCLES = 50000,
  parameter int               ALIGN_COMMIT   = 1
`ifdef UART_PWM_FRAME_CLAMP_EN
  ,
  parameter logic [WIDTH-1:0] DUTY_MAX       = '1
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      period_start,
  output logic [CHANNELS*WIDTH-1:0] duty_flat,
  output logic                      commit,
  output logic                      busy,
  output logic [3:0]                word_idx,
  output logic                      frame_err,
  output logic [1:0]                err_code,
  output logic [15:0]               frame_cnt
);

  localparam bit         ALIGN    = (ALIGN_COMMIT != 0);
  localparam logic [3:0] LAST_IDX = 4'(CHANNELS - 1);

  state_e state_q, state_d;

  logic [CHANNELS-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       idx_q, idx_d;
  logic             commit_q, commit_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             is_sync, in_frame, do_commit;
  logic             gap_clr, gap_en, gap_exp;
  logic [WIDTH-1:0] wr_word;

  assign is_sync  = in_valid && (in_data == SYNC_WORD);
  assign in_frame = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign gap_clr  = in_valid || !in_frame;
  assign gap_en   = in_frame && !in_valid;

`ifdef UART_PWM_FRAME_CLAMP_EN
  assign wr_word = (in_data > DUTY_MAX) ? DUTY_MAX : in_data;
`else
  assign wr_word = in_data;
`endif

  frame_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clr    (gap_clr),
    .en     (gap_en),
    .expired(gap_exp)
  );

  // Unaligned commits land one cycle after entering COMMIT; aligned
  // commits fire on period_start itself so they trail it by one cycle.
  assign do_commit = ALIGN ? (state_q == ST_PEND && period_start)
                           : (state_q == ST_COMMIT);

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    duty_d   = duty_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (is_sync) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (idx_q == 4'(k)) stage_d[k] = wr_word;
          end
          acc_d = acc_q ^ in_data;
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_d = ST_CHECK;
        end else if (gap_exp) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (in_valid) begin
          if (in_data == acc_q) begin
            state_d = ALIGN ? ST_PEND : ST_COMMIT;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end else if (gap_exp) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_PEND: begin
        if (in_valid) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (period_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (is_sync) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_commit) begin
      duty_d   = stage_q;
      commit_d = 1'b1;
      cnt_d    = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      duty_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      duty_q   <= duty_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
    end
  end

  assign duty_flat = duty_q;
  assign commit    = commit_q;
  assign busy      = (state_q != ST_IDLE);
  assign word_idx  = idx_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_uart_pwm_frame_ctrl.sv
// Bench: u0 commits unaligned, u1 waits for period_start.
module tb_uart_pwm_frame_ctrl;

  localparam int CH = 9;
  localparam logic [15:0] SYNC = 16'hA55A;

  typedef logic [CH-1:0][15:0] duty_t;

  typedef struct {
    logic [23:0][15:0] w;
    int                n;
    int                ncm;
    int                nfe;
    logic [1:0]        err;
    duty_t             duty;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic iv[2];
  logic [15:0] id[2];
  logic ps[2];
  logic [CH*16-1:0] duty[2];
  logic cm[2], by[2], fe[2];
  logic [3:0] wi[2];
  logic [1:0] ec[2];
  logic [15:0] fc[2];

  int n_cmp = 0;
  int n_bad = 0;
  int ncm[2];
  int nfe[2];

  duty_t ed[2];
  int exp_cnt[2], exp_ncm[2], exp_nfe[2];
  logic [1:0] exp_err[2];

  vec_t tv[6];

  always #5 clk = ~clk;

  uart_pwm_frame_ctrl #(
    .WIDTH(16), .CHANNELS(CH), .SYNC_WORD(SYNC),
    .TIMEOUT_CYCLES(100), .ALIGN_COMMIT(0)
`ifdef UART_PWM_FRAME_CLAMP_EN
    , .DUTY_MAX(16'h8000)
`endif
  ) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]),
    .period_start(ps[0]), .duty_flat(duty[0]), .commit(cm[0]),
    .busy(by[0]), .word_idx(wi[0]), .frame_err(fe[0]),
    .err_code(ec[0]), .frame_cnt(fc[0])
  );

  uart_pwm_frame_ctrl #(
    .WIDTH(16), .CHANNELS(CH), .SYNC_WORD(SYNC),
    .TIMEOUT_CYCLES(100), .ALIGN_COMMIT(1)
`ifdef UART_PWM_FRAME_CLAMP_EN
    , .DUTY_MAX(16'h8000)
`endif
  ) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]),
    .period_start(ps[1]), .duty_flat(duty[1]), .commit(cm[1]),
    .busy(by[1]), .word_idx(wi[1]), .frame_err(fe[1]),
    .err_code(ec[1]), .frame_cnt(fc[1])
  );

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (cm[s] === 1'b1) ncm[s]++;
      if (fe[s] === 1'b1) nfe[s]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] clampw(logic [15:0] w);
`ifdef UART_PWM_FRAME_CLAMP_EN
    return (w > 16'h8000) ? 16'h8000 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [15:0] csum(duty_t d);
    logic [15:0] x = '0;
    for (int k = 0; k < CH; k++) x ^= d[k];
    return x;
  endfunction

  task automatic chk(string nm, logic [143:0] act, logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic put(int s, logic [15:0] w);
    @(negedge clk);
    iv[s] = 1'b1;
    id[s] = w;
  endtask

  task automatic idle(int s, int n);
    repeat (n) begin
      @(negedge clk);
      iv[s] = 1'b0;
    end
  endtask

  task automatic send_frame(int s, duty_t d, logic [15:0] cs, int gap);
    put(s, SYNC);
    for (int k = 0; k < CH; k++) begin
      put(s, d[k]);
      if (gap > 0) idle(s, $urandom_range(0, gap));
    end
    put(s, cs);
    idle(s, 1);
  endtask

  task automatic model_commit(int s, duty_t d);
    for (int k = 0; k < CH; k++) ed[s][k] = clampw(d[k]);
    exp_cnt[s]++;
    exp_ncm[s]++;
  endtask

  task automatic model_err(int s, logic [1:0] code);
    exp_err[s] = code;
    exp_nfe[s]++;
  endtask

  task automatic check_dut(int s, string tag);
    chk($sformatf("%s_duty%0d", tag, s), duty[s], ed[s]);
    chk($sformatf("%s_cnt%0d", tag, s), fc[s], 16'(exp_cnt[s]));
    chk($sformatf("%s_err%0d", tag, s), ec[s], exp_err[s]);
    chk($sformatf("%s_ncm%0d", tag, s), ncm[s], exp_ncm[s]);
    chk($sformatf("%s_nfe%0d", tag, s), nfe[s], exp_nfe[s]);
    chk($sformatf("%s_busy%0d", tag, s), by[s], 1'b0);
  endtask

  task automatic add(int i, logic [15:0] w);
    tv[i].w[tv[i].n] = w;
    tv[i].n++;
  endtask

  task automatic add_frame(int i, duty_t d, logic [15:0] cs);
    add(i, SYNC);
    for (int k = 0; k < CH; k++) add(i, d[k]);
    add(i, cs);
  endtask

  task automatic check_zero(int s, string tag);
    chk({tag, "_duty"}, duty[s], '0);
    chk({tag, "_flags"}, {cm[s], by[s], fe[s]}, 3'b000);
    chk({tag, "_idx"}, wi[s], 4'd0);
    chk({tag, "_err"}, ec[s], 2'b00);
    chk({tag, "_cnt"}, fc[s], 16'd0);
  endtask

  initial begin
    duty_t d, d2;
    logic [15:0] cs, j;
    bit good, sawc;
    int c0, e0;

    // Vector table, expected outputs written out from the frame rules.
    for (int i = 0; i < 6; i++) tv[i].n = 0;
    for (int k = 0; k < CH; k++) d[k] = 16'(k);
    add_frame(0, d, 16'h0008);
    tv[0].ncm = 1; tv[0].nfe = 0; tv[0].err = 2'b00; tv[0].duty = d;
    add_frame(1, d, 16'h0009);
    tv[1].ncm = 0; tv[1].nfe = 1; tv[1].err = 2'b01; tv[1].duty = d;
    add(2, 16'h1234);
    add(2, 16'hFFFF);
    for (int k = 0; k < CH; k++) d[k] = 16'(k * 16'h1111);
    add_frame(2, d, csum(d));
    tv[2].ncm = 1; tv[2].nfe = 0; tv[2].err = 2'b01;
    for (int k = 0; k < CH; k++) tv[2].duty[k] = clampw(d[k]);
    for (int k = 0; k < CH; k++) d[k] = 16'(k);
    d[0] = SYNC;
    add_frame(3, d, csum(d));
    tv[3].ncm = 1; tv[3].nfe = 0; tv[3].err = 2'b01;
    for (int k = 0; k < CH; k++) tv[3].duty[k] = clampw(d[k]);
    for (int k = 0; k < CH; k++) d[k] = 16'(16'h100 + k);
    add_frame(4, d, csum(d));
    for (int k = 0; k < CH; k++) d[k] = 16'(16'h200 + k);
    add_frame(4, d, csum(d));
    tv[4].ncm = 2; tv[4].nfe = 0; tv[4].err = 2'b01; tv[4].duty = d;
    for (int k = 0; k < CH; k++) d[k] = 16'(16'h50 + k);
    add_frame(5, d, csum(d) ^ 16'h0001);
    for (int k = 0; k < CH; k++) d[k] = 16'(16'h300 + k);
    add_frame(5, d, csum(d));
    tv[5].ncm = 1; tv[5].nfe = 1; tv[5].err = 2'b01; tv[5].duty = d;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; id[s] = '0; ps[s] = 1'b0;
      ed[s] = '0; exp_cnt[s] = 0; exp_err[s] = 2'b00;
      exp_ncm[s] = 0; exp_nfe[s] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      c0 = ncm[0];
      e0 = nfe[0];
      for (int k = 0; k < tv[i].n; k++) put(0, tv[i].w[k]);
      idle(0, 4);
      chk($sformatf("vec%0d_commits", i), ncm[0] - c0, tv[i].ncm);
      chk($sformatf("vec%0d_errs", i), nfe[0] - e0, tv[i].nfe);
      chk($sformatf("vec%0d_code", i), ec[0], tv[i].err);
      chk($sformatf("vec%0d_duty", i), duty[0], tv[i].duty);
      exp_cnt[0] += tv[i].ncm;
      exp_ncm[0] += tv[i].ncm;
      exp_nfe[0] += tv[i].nfe;
      exp_err[0] = tv[i].err;
      ed[0] = tv[i].duty;
      chk($sformatf("vec%0d_cnt", i), fc[0], 16'(exp_cnt[0]));
    end

    // Unaligned latency: commit visible two cycles after checksum.
    for (int k = 0; k < CH; k++) d[k] = 16'(16'h0A00 + k);
    put(0, SYNC);
    for (int k = 0; k < CH; k++) put(0, d[k]);
    put(0, csum(d));
    idle(0, 1);
    chk("lat_t1", cm[0], 1'b0);
    idle(0, 1);
    chk("lat_t2", cm[0], 1'b1);
    chk("lat_duty", duty[0], d);
    idle(0, 1);
    chk("lat_t3", cm[0], 1'b0);
    model_commit(0, d);
    idle(0, 2);
    check_dut(0, "lat");

    // Gap timeout after four duties.
    put(0, SYNC);
    for (int k = 0; k < 4; k++) put(0, 16'(16'h10 + k));
    idle(0, 1);
    chk("to_idx", wi[0], 4'd4);
    idle(0, 99);
    chk("to_before", {fe[0], by[0]}, 2'b01);
    idle(0, 1);
    chk("to_fire", {fe[0], ec[0], by[0]}, 4'b1100);
    model_err(0, 2'b10);
    for (int k = 0; k < CH; k++) d[k] = 16'(16'h0B00 + k);
    send_frame(0, d, csum(d), 0);
    idle(0, 3);
    model_commit(0, d);
    check_dut(0, "to_after");

    // Aligned commit, with a stray period_start during LOAD.
    for (int k = 0; k < CH; k++) d[k] = 16'(16'h0400 + k);
    put(1, SYNC);
    for (int k = 0; k < CH; k++) begin
      put(1, d[k]);
      ps[1] = (k == 2);
    end
    put(1, csum(d));
    ps[1] = 1'b0;
    sawc = 1'b0;
    repeat (37) begin
      @(negedge clk);
      iv[1] = 1'b0;
      sawc |= cm[1];
    end
    chk("al_early", sawc, 1'b0);
    chk("al_busy", by[1], 1'b1);
    @(negedge clk);
    ps[1] = 1'b1;
    @(negedge clk);
    ps[1] = 1'b0;
    chk("al_commit", cm[1], 1'b1);
    chk("al_duty", duty[1], d);
    @(negedge clk);
    chk("al_pulse", cm[1], 1'b0);
    model_commit(1, d);

    // Overrun word in PEND; commit still happens.
    for (int k = 0; k < CH; k++) d2[k] = 16'(16'h0500 + k);
    send_frame(1, d2, csum(d2), 0);
    idle(1, 2);
    put(1, 16'h5555);
    idle(1, 1);
    chk("ov_err", {fe[1], ec[1]}, 3'b111);
    model_err(1, 2'b11);
    sawc = 1'b0;
    repeat (5) begin
      @(negedge clk);
      sawc |= cm[1];
    end
    chk("ov_hold", {sawc, duty[1]}, {1'b0, d});
    ps[1] = 1'b1;
    @(negedge clk);
    ps[1] = 1'b0;
    chk("ov_commit", cm[1], 1'b1);
    model_commit(1, d2);
    idle(1, 3);
    check_dut(1, "ov");

    // Reset mid-LOAD aborts silently.
    put(0, SYNC);
    for (int k = 0; k < 5; k++) put(0, 16'(16'h20 + k));
    @(negedge clk);
    iv[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero(0, "mid_rst");
    for (int s = 0; s < 2; s++) begin
      ed[s] = '0; exp_cnt[s] = 0; exp_err[s] = 2'b00;
    end
    for (int k = 0; k < CH; k++) d[k] = 16'(16'h0C00 + k);
    send_frame(0, d, csum(d), 0);
    idle(0, 3);
    model_commit(0, d);
    check_dut(0, "post_rst");
    check_dut(1, "post_rst");

`ifdef UART_PWM_FRAME_CLAMP_EN
    for (int k = 0; k < CH; k++) d[k] = 16'h0100;
    d[4] = 16'hFFFF;
    send_frame(0, d, csum(d), 0);
    idle(0, 3);
    chk("clamp_ch4", duty[0][4*16 +: 16], 16'h8000);
    model_commit(0, d);
    check_dut(0, "clamp");
`endif

    // Random frames against the frame-level model.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        j = 16'($urandom);
        if (j == SYNC) j = 16'h0001;
        put(0, j);
      end
      for (int k = 0; k < CH; k++) begin
        d[k] = 16'($urandom);
        if ($urandom_range(0, 9) == 0) d[k] = SYNC;
      end
      cs = csum(d);
      good = ($urandom_range(0, 3) != 0);
      if (!good) cs ^= 16'(1 << $urandom_range(0, 15));
      send_frame(0, d, cs, 3);
      idle(0, 3);
      if (good) model_commit(0, d);
      else model_err(0, 2'b01);
      check_dut(0, $sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
